// File: rtl/scan_master.sv
// Serial master for the PLL/FLL configuration scan chain: shifts a word in MSB-first and applies it,
// or captures the applied word and shifts it back out. Define SCAN_VERIFY_EN for automatic write readback.
module scan_master #(
  parameter int N       = 96,
  parameter int CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] rdata,
  output logic         mismatch,
  output logic         sr_clk,
  output logic         sr_s_out,
  input  logic         sr_s_in,
  output logic         sr_load,
  output logic         sr_read
);

  localparam int CW = $clog2(N + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [DW-1:0]  r_div;
  logic [N-1:0]   r_sr;
  logic [N-1:0]   r_shadow;
  logic [N-1:0]   r_rdata;
  logic           r_rd_phase;
  logic           r_busy;
  logic           r_done;
  logic           r_sr_clk;
  logic           r_s_out;
  logic           r_load;
  logic           r_read;
`ifdef SCAN_VERIFY_EN
  logic [N-1:0]   r_wdata;
  logic           r_is_write;
  logic           r_mismatch;
`endif

  logic w_active;
  logic w_low_end;
  logic w_pulse_end;

  assign w_active    = (r_state == S_CAPTURE) || (r_state == S_SHIFT) || (r_state == S_LOAD);
  // Last clk of a low phase (chain rises next) and last clk of a high phase (next pulse starts).
  assign w_low_end   = w_active && !r_sr_clk && (r_div == DIV_LAST);
  assign w_pulse_end = w_active &&  r_sr_clk && (r_div == DIV_LAST);

  // NOTE: every register here is state with a defined reset value, all updated with <= so
  // that each branch sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_sr       <= '0;
      r_shadow   <= '0;
      r_rdata    <= '0;
      r_rd_phase <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sr_clk   <= 1'b0;
      r_s_out    <= 1'b0;
      r_load     <= 1'b0;
      r_read     <= 1'b0;
`ifdef SCAN_VERIFY_EN
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_mismatch <= 1'b0;
`endif
    end else begin
      if (w_active) begin
        if (r_div == DIV_LAST) begin
          r_div    <= '0;
          r_sr_clk <= ~r_sr_clk;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end

      if (w_low_end && (r_state == S_SHIFT) && r_rd_phase)
        r_shadow <= {r_shadow[N-2:0], sr_s_in};

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr       <= wdata;
            r_cnt      <= CNT_INIT;
            r_rd_phase <= op;
            r_busy     <= 1'b1;
            r_div      <= '0;
            r_sr_clk   <= 1'b0;
            r_s_out    <= op ? 1'b0 : wdata[N-1];
            r_read     <= op;
            r_state    <= op ? S_CAPTURE : S_SHIFT;
`ifdef SCAN_VERIFY_EN
            r_wdata    <= wdata;
            r_is_write <= ~op;
            r_mismatch <= 1'b0;
`endif
          end
        end

        S_CAPTURE: begin
          if (w_pulse_end) begin
            r_read  <= 1'b0;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_pulse_end) begin
            r_cnt   <= r_cnt - 1'b1;
            r_sr    <= r_sr << 1;
            r_s_out <= r_rd_phase ? 1'b0 : r_sr[N-2];
            if (r_cnt == CNT_LAST) begin
              r_s_out <= 1'b0;
              if (r_rd_phase) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_rdata <= r_shadow;
`ifdef SCAN_VERIFY_EN
                r_mismatch <= r_is_write && (r_shadow != r_wdata);
`endif
              end else begin
                r_state <= S_LOAD;
                r_load  <= 1'b1;
              end
            end
          end
        end

        S_LOAD: begin
          if (w_pulse_end) begin
            r_load <= 1'b0;
`ifdef SCAN_VERIFY_EN
            // Read the freshly applied word back through the chain before finishing.
            r_state    <= S_CAPTURE;
            r_read     <= 1'b1;
            r_rd_phase <= 1'b1;
            r_cnt      <= CNT_INIT;
`else
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign sr_clk   = r_sr_clk;
  assign sr_s_out = r_s_out;
  assign sr_load  = r_load;
  assign sr_read  = r_read;
`ifdef SCAN_VERIFY_EN
  assign mismatch = r_mismatch;
`else
  assign mismatch = 1'b0;
`endif

endmodule
